bcd_serial_sub: RTL
===================

Name: bcd_serial_sub

Overview:
- Multi-digit packed-BCD subtractor computing A − B − bin.
- Processes one decimal digit per clock, least-significant digit first, and returns a signed-magnitude BCD result.
- It is the subtract direction of the team's BCD adder, for use in the calculator datapath next to the digit-serial adder.
- Uses a start/busy/done handshake so a controlling FSM can sequence operations.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width = 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- a  input  4*DIGITS  minuend, packed BCD, digit 0 at bits [3:0].
- b  input  4*DIGITS  subtrahend, packed BCD.
- bin  input  1  borrow in, subtracted at digit 0.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/neg/invalid are updated.
- diff  output  4*DIGITS  BCD magnitude of the result.
- neg  output  1  result is negative.
- invalid  output  1  an operand digit was greater than 9.

Behaviour:
- Reset (synchronous, active-high, clk):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset overrides everything, including an operation in progress; the partial result is discarded and done is not pulsed.
- States: IDLE, SUB, FIX, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1, latch a, b and bin, clear the digit index and the borrow (borrow := bin), and set busy=1.
  - If any latched digit of a or b is greater than 9, go to DONE with invalid flagged; otherwise go to SUB.
- SUB: one digit per edge, index i = 0..DIGITS-1.
  - t = a_i − b_i − borrow, computed as a 5-bit signed value.
  - If t < 0: raw_i = t + 10, borrow = 1. Otherwise raw_i = t, borrow = 0.
  - After digit DIGITS-1:
    - final borrow = 0 → go to DONE with neg=0 and diff=raw.
    - final borrow = 1 → go to FIX.
- FIX: result is negative. Compute the magnitude 10^DIGITS − raw.
  - Use the same digit-serial subtraction 0 − raw_i − borrow, starting with borrow = 0, one digit per edge, DIGITS edges.
  - Then go to DONE with neg=1.
- DONE:
  - diff, neg and invalid are registered at the edge that enters DONE.
  - done=1 for exactly that one cycle; busy=1 in that cycle.
  - The next edge returns to IDLE with busy=0 and done=0.
- Invalid path: diff=0, neg=0, invalid=1.
- Outputs diff, neg and invalid hold their value until the next DONE entry; they are not cleared by start.
- Latency, with start sampled at edge k:
  - done is high in the cycle after edge k+DIGITS when the result is non-negative.
  - After edge k+2*DIGITS when it is negative.
  - After edge k+1 when invalid.
- start while busy=1 (including the DONE cycle) is ignored; it does not queue.
- Operand inputs may change after the start edge; only the latched copies are used.
- Zero results are never negative: A = B with bin=0 gives diff=0, neg=0.
- Every output digit is always within 0..9.

Test Plan (DIGITS=4):
- Non-negative result: a=0x5432, b=0x1234, bin=0, start pulse → done 4 cycles later; diff=0x4198, neg=0, invalid=0; busy high from the cycle after start through the done cycle.
- Negative result: a=0x1234, b=0x5432, bin=0 → done 8 cycles after start; diff=0x4198, neg=1.
- Borrow chain and borrow-in:
  - a=0x1000, b=0x0001, bin=1 → diff=0x0998, neg=0.
  - a=0x0000, b=0x0000, bin=1 → diff=0x0001, neg=1.
  - a=b=0x9999, bin=0 → diff=0x0000, neg=0.
- Invalid digit: a=0x00A0, b=0x0001 → done 1 cycle after start; invalid=1, diff=0, neg=0.
  - A following valid operation (0x0005 − 0x0003) clears invalid and returns diff=0x0002.
- Start while busy: issue start at cycle 2 of a running operation with different operands → ignored; the first result is unchanged and exactly one done pulse occurs.
- Reset mid-operation: assert rst during the FIX state → next cycle busy=0, done=0, diff=0, neg=0; a new start afterwards produces a correct result with normal latency.

Source files
------------

// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: A - B - bin, LSD first.
// Signed-magnitude result with start/busy/done handshake.
module bcd_serial_sub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  raw_q, raw_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          neg_q, neg_d;
  logic          inv_q, inv_d;

  logic          bad;
  logic [3:0]    op_x, op_y;
  logic [4:0]    t;
  logic [4:0]    t_adj;
  logic [3:0]    dig;
  logic          bout;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[4*i +: 4] > 4'd9) bad = 1'b1;
      if (b_q[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // FIX reuses the digit subtractor as 0 - raw_i - borrow
  always_comb begin
    op_x  = (state_q == S_FIX) ? 4'd0 : a_q[4*idx_q +: 4];
    op_y  = (state_q == S_FIX) ? raw_q[4*idx_q +: 4]
                               : b_q[4*idx_q +: 4];
    t     = {1'b0, op_x} - {1'b0, op_y} - {4'd0, borrow_q};
    t_adj = t + 5'd10;
    bout  = t[4];
    dig   = bout ? t_adj[3:0] : t[3:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    inv_d    = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = S_SUB;
        end
      end
      S_SUB: begin
        if (bad) begin
          diff_d  = '0;
          neg_d   = 1'b0;
          inv_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          raw_d[4*idx_q +: 4] = dig;
          borrow_d = bout;
          if (idx_q == LAST) begin
            idx_d = '0;
            if (bout) begin
              borrow_d = 1'b0;
              state_d  = S_FIX;
            end else begin
              diff_d  = raw_d;
              neg_d   = 1'b0;
              inv_d   = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_FIX: begin
        raw_d[4*idx_q +: 4] = dig;
        borrow_d = bout;
        if (idx_q == LAST) begin
          idx_d   = '0;
          diff_d  = raw_d;
          neg_d   = 1'b1;
          inv_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      inv_q    <= inv_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = inv_q;

endmodule
